// File: rtl/demux_rr_scheduler_pkg.sv
// Shared constants and state encoding for the round-robin demux scheduler.
package demux_rr_scheduler_pkg;

    localparam int unsigned N_CH    = 16;
    localparam int unsigned SEL_W   = 4;
    localparam int unsigned DWELL_W = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGrant = 2'd1,
        StGap   = 2'd2
    } state_e;

endpackage

// File: rtl/demux_rr_scheduler_pick.sv
// Rotating-priority picker: the first set request bit at or above last+1, wrapping 15 -> 0.
module rr_priority_pick
    import demux_rr_scheduler_pkg::*;
(
    input  logic [N_CH-1:0]  req_i,
    input  logic [SEL_W-1:0] last_i,
    output logic [SEL_W-1:0] winner_o,
    output logic             valid_o
);

    logic [SEL_W-1:0]  start;
    logic [2*N_CH-1:0] dbl;
    logic [N_CH-1:0]   rot;
    logic [SEL_W-1:0]  idx;

    assign start = last_i + SEL_W'(1);

    always_comb begin
        dbl = {req_i, req_i};
        rot = dbl[start +: N_CH];
        idx = '0;
        // Scan downward so the lowest set bit is the one that sticks.
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                idx = SEL_W'(i);
            end
        end
    end

    assign winner_o = idx + start;
    assign valid_o  = |req_i;

endmodule

// File: rtl/demux_rr_scheduler.sv
// Round-robin owner of a shared 1:16 demux: dwell-limited grants with a one-cycle
// break-before-make gap between grants.
module demux_rr_scheduler
    import demux_rr_scheduler_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [N_CH-1:0]    req_i,
    input  logic [DWELL_W-1:0] dwell_i,
    input  logic               release_i,
    output logic [SEL_W-1:0]   sel_o,
    output logic               en_o,
    output logic [N_CH-1:0]    grant_o,
    output logic               busy_o
);

    state_e             state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0]   last_q, last_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               en_q, en_d;
    logic [N_CH-1:0]    grant_q, grant_d;
    logic               busy_q, busy_d;

    logic [SEL_W-1:0]   pick_winner;
    logic               pick_valid;

    rr_priority_pick u_pick (
        .req_i    (req_i),
        .last_i   (last_q),
        .winner_o (pick_winner),
        .valid_o  (pick_valid)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        sel_d   = sel_q;
        en_d    = 1'b0;
        grant_d = '0;
        busy_d  = 1'b0;
        case (state_q)
            StIdle, StGap: begin
                if (pick_valid) begin
                    state_d = StGrant;
                    sel_d   = pick_winner;
                    last_d  = pick_winner;
                    en_d    = 1'b1;
                    grant_d = N_CH'(1) << pick_winner;
                    busy_d  = 1'b1;
                    // Dwell of 0 behaves as 1; counter holds remaining cycles after this one.
                    cnt_d   = (dwell_i == '0) ? '0 : dwell_i - DWELL_W'(1);
                end else begin
                    state_d = StIdle;
                end
            end
            StGrant: begin
                busy_d = 1'b1;
                if (cnt_q == '0 || release_i || !req_i[sel_q]) begin
                    state_d = StGap;
                end else begin
                    cnt_d   = cnt_q - DWELL_W'(1);
                    en_d    = 1'b1;
                    grant_d = grant_q;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            last_q  <= SEL_W'(N_CH - 1);
            sel_q   <= '0;
            en_q    <= 1'b0;
            grant_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
        end
    end

    assign sel_o   = sel_q;
    assign en_o    = en_q;
    assign grant_o = grant_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Self-checking bench for demux_rr_scheduler: per-cycle vector tables with a scoreboard queue.
module tb_demux_rr_scheduler;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic [7:0]  dwell;
    logic        rel;
    logic [3:0]  sel;
    logic        en;
    logic [15:0] grant;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] req;
        logic [7:0]  dwell;
        logic        rel;
        logic        en;
        logic [3:0]  sel;
        logic        busy;
    } vec_t;

    typedef struct {
        logic        en;
        logic [3:0]  sel;
        logic [15:0] grant;
        logic        busy;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    demux_rr_scheduler dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .req_i     (req),
        .dwell_i   (dwell),
        .release_i (rel),
        .sel_o     (sel),
        .en_o      (en),
        .grant_o   (grant),
        .busy_o    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [15:0] r, input logic [7:0] d, input logic rl,
                       input logic e, input logic [3:0] s, input logic b);
        vec_t v;
        v.req = r; v.dwell = d; v.rel = rl; v.en = e; v.sel = s; v.busy = b;
        tbl.push_back(v);
    endtask

    task automatic run_tbl(input string name);
        exp_t x;
        exp_t got;
        for (int i = 0; i < tbl.size(); i++) begin
            req   = tbl[i].req;
            dwell = tbl[i].dwell;
            rel   = tbl[i].rel;
            x.en    = tbl[i].en;
            x.sel   = tbl[i].sel;
            x.grant = tbl[i].en ? (16'h0001 << tbl[i].sel) : 16'h0000;
            x.busy  = tbl[i].busy;
            sb.push_back(x);
            @(posedge clk);
            #1;
            got = sb.pop_front();
            chk($sformatf("%s[%0d].en", name, i), {15'd0, en}, {15'd0, got.en});
            chk($sformatf("%s[%0d].sel", name, i), {12'd0, sel}, {12'd0, got.sel});
            chk($sformatf("%s[%0d].grant", name, i), grant, got.grant);
            chk($sformatf("%s[%0d].busy", name, i), {15'd0, busy}, {15'd0, got.busy});
        end
        tbl.delete();
    endtask

    // Reset asserted between edges must clear outputs with no clock edge.
    task automatic do_reset(input string name, input logic [15:0] r, input logic [7:0] d);
        #2;
        rst_n = 1'b0;
        #1;
        chk({name, ".en"}, {15'd0, en}, 16'h0000);
        chk({name, ".sel"}, {12'd0, sel}, 16'h0000);
        chk({name, ".grant"}, grant, 16'h0000);
        chk({name, ".busy"}, {15'd0, busy}, 16'h0000);
        req   = r;
        dwell = d;
        rel   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        req   = 16'h0000;
        dwell = 8'd1;
        rel   = 1'b0;
        #1;
        do_reset("reset0", 16'hFFFF, 8'd1);
        @(posedge clk);
        #1;
        chk("first.en", {15'd0, en}, 16'h0001);
        chk("first.sel", {12'd0, sel}, 16'h0000);
        chk("first.grant", grant, 16'h0001);
        chk("first.busy", {15'd0, busy}, 16'h0001);

        // All requesting: gap, then rotation to channel 1, then drain to idle.
        add(16'hFFFF, 8'd1, 1'b0, 1'b0, 4'd0, 1'b1);
        add(16'hFFFF, 8'd1, 1'b0, 1'b1, 4'd1, 1'b1);
        add(16'h0000, 8'd1, 1'b0, 1'b0, 4'd1, 1'b1);
        add(16'h0000, 8'd1, 1'b0, 1'b0, 4'd1, 1'b0);
        run_tbl("all");

        // Sole requester, dwell 3; dwell changes mid-grant are ignored.
        add(16'h0020, 8'd3, 1'b0, 1'b1, 4'd5, 1'b1);
        add(16'h0020, 8'd0, 1'b0, 1'b1, 4'd5, 1'b1);
        add(16'h0020, 8'd0, 1'b0, 1'b1, 4'd5, 1'b1);
        add(16'h0020, 8'd3, 1'b0, 1'b0, 4'd5, 1'b1);
        add(16'h0020, 8'd3, 1'b0, 1'b1, 4'd5, 1'b1);
        add(16'h0000, 8'd3, 1'b0, 1'b0, 4'd5, 1'b1);
        add(16'h0000, 8'd3, 1'b0, 1'b0, 4'd5, 1'b0);
        run_tbl("single");

        do_reset("reset1", 16'h0000, 8'd2);

        // Wrap-around between channels 0 and 15, dwell 2.
        for (int k = 0; k < 4; k++) begin
            add(16'h8001, 8'd2, 1'b0, 1'b1, (k % 2 == 0) ? 4'd0 : 4'd15, 1'b1);
            if (k < 3) begin
                add(16'h8001, 8'd2, 1'b0, 1'b1, (k % 2 == 0) ? 4'd0 : 4'd15, 1'b1);
                add(16'h8001, 8'd2, 1'b0, 1'b0, (k % 2 == 0) ? 4'd0 : 4'd15, 1'b1);
            end
        end
        add(16'h8001, 8'd2, 1'b0, 1'b1, 4'd15, 1'b1);
        add(16'h0000, 8'd2, 1'b0, 1'b0, 4'd15, 1'b1);
        add(16'h0000, 8'd2, 1'b0, 1'b0, 4'd15, 1'b0);
        run_tbl("wrap");

        // Request drop on grant cycle 2 of a dwell-10 grant.
        add(16'h0008, 8'd10, 1'b0, 1'b1, 4'd3, 1'b1);
        add(16'h0008, 8'd10, 1'b0, 1'b1, 4'd3, 1'b1);
        add(16'h0000, 8'd10, 1'b0, 1'b0, 4'd3, 1'b1);
        add(16'h0000, 8'd10, 1'b0, 1'b0, 4'd3, 1'b0);
        run_tbl("drop");

        // Release in grant cycle 1, then release coinciding with counter expiry.
        add(16'h0008, 8'd10, 1'b0, 1'b1, 4'd3, 1'b1);
        add(16'h0008, 8'd10, 1'b1, 1'b0, 4'd3, 1'b1);
        add(16'h0008, 8'd10, 1'b0, 1'b1, 4'd3, 1'b1);
        add(16'h0000, 8'd10, 1'b0, 1'b0, 4'd3, 1'b1);
        add(16'h0000, 8'd10, 1'b0, 1'b0, 4'd3, 1'b0);
        add(16'h0008, 8'd1, 1'b0, 1'b1, 4'd3, 1'b1);
        add(16'h0008, 8'd1, 1'b1, 1'b0, 4'd3, 1'b1);
        add(16'h0000, 8'd1, 1'b0, 1'b0, 4'd3, 1'b0);
        run_tbl("release");

        // Dwell 0 acts as 1: alternating single-cycle grants.
        add(16'h0006, 8'd0, 1'b0, 1'b1, 4'd1, 1'b1);
        add(16'h0006, 8'd0, 1'b0, 1'b0, 4'd1, 1'b1);
        add(16'h0006, 8'd0, 1'b0, 1'b1, 4'd2, 1'b1);
        add(16'h0006, 8'd0, 1'b0, 1'b0, 4'd2, 1'b1);
        add(16'h0006, 8'd0, 1'b0, 1'b1, 4'd1, 1'b1);
        add(16'h0006, 8'd0, 1'b0, 1'b0, 4'd1, 1'b1);
        add(16'h0006, 8'd0, 1'b0, 1'b1, 4'd2, 1'b1);
        run_tbl("dwell0");

        // Reset during the channel-2 grant; pointer returns so channel 1 wins next.
        do_reset("reset_mid", 16'h0006, 8'd0);
        add(16'h0006, 8'd0, 1'b0, 1'b1, 4'd1, 1'b1);
        add(16'h0006, 8'd0, 1'b0, 1'b0, 4'd1, 1'b1);
        add(16'h0006, 8'd0, 1'b0, 1'b1, 4'd2, 1'b1);
        run_tbl("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
